// File: rtl/bounding_box_pipe.sv
// bounding_box_pipe: triangle bounding-box stage for the rasterizer.
//
// Takes three vertices in a sign/exponent/mantissa float format and computes
// min/max X and Y. Each result is flagged degenerate when the box has zero
// width or height. Results are buffered in an output FIFO.
//
// Pipeline:
//   S1   v1-vs-v2 min/max per axis; v3 is carried along.
//   S2   folds in v3, applies the optional scissor and the degenerate check.
//   FIFO circular buffer. Its credit count includes in-flight results, so
//        the pipeline never stalls.
//
// Handshake:
//   Accept on nd && us_rfd.
//   Pop on rdy && ds_rfd.
//
// Optional build macro BOUNDING_BOX_SCISSOR_EN:
//   Adds sc_minX/sc_maxX/sc_minY/sc_maxY inputs.
//   Clamps the box to the scissor window.
//   Raises cull for boxes that lie completely outside the window.
//   Without it, cull is tied to 0 and latency is the same.
//
// Reset is asynchronous and active-low on rst.
module bounding_box_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int DEPTH = 4,
  localparam int FP_W = 1 + EXP_W + MAN_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            nd,
  output logic            us_rfd,
  input  logic [FP_W-1:0] v1_posX,
  input  logic [FP_W-1:0] v1_posY,
  input  logic [FP_W-1:0] v2_posX,
  input  logic [FP_W-1:0] v2_posY,
  input  logic [FP_W-1:0] v3_posX,
  input  logic [FP_W-1:0] v3_posY,
  input  logic            ds_rfd,
  output logic            rdy,
  output logic [FP_W-1:0] fp_minX,
  output logic [FP_W-1:0] fp_maxX,
  output logic [FP_W-1:0] fp_minY,
  output logic [FP_W-1:0] fp_maxY,
  output logic            degen,
  output logic            cull
`ifdef BOUNDING_BOX_SCISSOR_EN
  ,
  input  logic [FP_W-1:0] sc_minX,
  input  logic [FP_W-1:0] sc_maxX,
  input  logic [FP_W-1:0] sc_minY,
  input  logic [FP_W-1:0] sc_maxY
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  typedef struct packed {
    logic [FP_W-1:0] min_x;
    logic [FP_W-1:0] max_x;
    logic [FP_W-1:0] min_y;
    logic [FP_W-1:0] max_y;
  } box_t;

  typedef struct packed {
    box_t box;
    logic degen;
    logic cull;
  } entry_t;

  // Maps a float bit pattern to an unsigned key with the same total order.
  // The order has -0 below +0; NaNs simply sort by their bits.
  function automatic logic [FP_W-1:0] fp_key(input logic [FP_W-1:0] b);
    return b[FP_W-1] ? ~b : (b | {1'b1, {(FP_W-1){1'b0}}});
  endfunction

  function automatic logic key_lt(input logic [FP_W-1:0] a, input logic [FP_W-1:0] b);
    return fp_key(a) < fp_key(b);
  endfunction

  // 'a' is the lower vertex index, so a tie keeps a's bits.
  function automatic logic [FP_W-1:0] pick_min(input logic [FP_W-1:0] a,
                                               input logic [FP_W-1:0] b);
    return key_lt(b, a) ? b : a;
  endfunction

  function automatic logic [FP_W-1:0] pick_max(input logic [FP_W-1:0] a,
                                               input logic [FP_W-1:0] b);
    return key_lt(a, b) ? b : a;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic            s1_valid_q, s1_valid_d;
  box_t            s1_box_q, s1_box_d;
  logic [FP_W-1:0] s1_v3x_q, s1_v3x_d;
  logic [FP_W-1:0] s1_v3y_q, s1_v3y_d;
`ifdef BOUNDING_BOX_SCISSOR_EN
  box_t            s1_sc_q, s1_sc_d;
`endif
  logic            s2_valid_q, s2_valid_d;
  entry_t          s2_entry_q, s2_entry_d;

  entry_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  entry_t          hold_q, hold_d;
  logic            rfd_en_q, rfd_en_d;

  logic            accept;
  logic            push;
  logic            pop;
  logic [OCC_W-1:0] occupancy;
  entry_t          head;
  entry_t          out_entry;

  // Credit check, computed from registered state only.
  // rfd_en_q keeps us_rfd low while in reset.
  always_comb begin
    occupancy = OCC_W'(count_q) + OCC_W'(s1_valid_q) + OCC_W'(s2_valid_q);
    us_rfd    = rfd_en_q && (occupancy < OCC_W'(DEPTH));
    accept    = nd && us_rfd;
    rdy       = (count_q != '0);
    pop       = rdy && ds_rfd;
    push      = s2_valid_q;
  end

  // S1: v1-vs-v2 min/max per axis. Captures v3, and the scissor if present.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves it unassigned and no latch is inferred.
    s1_valid_d = accept;
    s1_box_d   = s1_box_q;
    s1_v3x_d   = s1_v3x_q;
    s1_v3y_d   = s1_v3y_q;
`ifdef BOUNDING_BOX_SCISSOR_EN
    s1_sc_d    = s1_sc_q;
`endif
    if (accept) begin
      s1_box_d.min_x = pick_min(v1_posX, v2_posX);
      s1_box_d.max_x = pick_max(v1_posX, v2_posX);
      s1_box_d.min_y = pick_min(v1_posY, v2_posY);
      s1_box_d.max_y = pick_max(v1_posY, v2_posY);
      s1_v3x_d       = v3_posX;
      s1_v3y_d       = v3_posY;
`ifdef BOUNDING_BOX_SCISSOR_EN
      s1_sc_d.min_x  = sc_minX;
      s1_sc_d.max_x  = sc_maxX;
      s1_sc_d.min_y  = sc_minY;
      s1_sc_d.max_y  = sc_maxY;
`endif
    end
  end

  // S2: fold in v3, apply the optional scissor, then the degenerate check.
  always_comb begin
    box_t full;
    box_t clamped;
    logic cull_flag;
    full.min_x = pick_min(s1_box_q.min_x, s1_v3x_q);
    full.max_x = pick_max(s1_box_q.max_x, s1_v3x_q);
    full.min_y = pick_min(s1_box_q.min_y, s1_v3y_q);
    full.max_y = pick_max(s1_box_q.max_y, s1_v3y_q);
`ifdef BOUNDING_BOX_SCISSOR_EN
    cull_flag     = key_lt(full.max_x, s1_sc_q.min_x) || key_lt(s1_sc_q.max_x, full.min_x) ||
                    key_lt(full.max_y, s1_sc_q.min_y) || key_lt(s1_sc_q.max_y, full.min_y);
    clamped.min_x = pick_max(full.min_x, s1_sc_q.min_x);
    clamped.max_x = pick_min(full.max_x, s1_sc_q.max_x);
    clamped.min_y = pick_max(full.min_y, s1_sc_q.min_y);
    clamped.max_y = pick_min(full.max_y, s1_sc_q.max_y);
`else
    cull_flag     = 1'b0;
    clamped       = full;
`endif
    s2_valid_d = s1_valid_q;
    s2_entry_d = s2_entry_q;
    if (s1_valid_q) begin
      s2_entry_d.box   = clamped;
      s2_entry_d.cull  = cull_flag;
      s2_entry_d.degen = (clamped.min_x == clamped.max_x) ||
                         (clamped.min_y == clamped.max_y);
    end
  end

  // FIFO bookkeeping: pointers, count, and the last-popped value.
  // Push comes from S2; pop comes from the downstream handshake.
  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    head     = mem_q[rd_ptr_q];
    hold_d   = pop ? head : hold_q;
    rfd_en_d = 1'b1;
  end

  // Outputs show the head entry while rdy is high.
  // Otherwise they hold the last popped entry.
  always_comb begin
    out_entry = rdy ? head : hold_q;
    fp_minX   = out_entry.box.min_x;
    fp_maxX   = out_entry.box.max_x;
    fp_minY   = out_entry.box.min_y;
    fp_maxY   = out_entry.box.max_y;
    degen     = out_entry.degen;
    cull      = out_entry.cull;
  end

  // Control and pipeline state registers, cleared by async reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments, so every flop updates from pre-edge values.
      s1_valid_q <= 1'b0;
      s1_box_q   <= '0;
      s1_v3x_q   <= '0;
      s1_v3y_q   <= '0;
`ifdef BOUNDING_BOX_SCISSOR_EN
      s1_sc_q    <= '0;
`endif
      s2_valid_q <= 1'b0;
      s2_entry_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      hold_q     <= '0;
      rfd_en_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_box_q   <= s1_box_d;
      s1_v3x_q   <= s1_v3x_d;
      s1_v3y_q   <= s1_v3y_d;
`ifdef BOUNDING_BOX_SCISSOR_EN
      s1_sc_q    <= s1_sc_d;
`endif
      s2_valid_q <= s2_valid_d;
      s2_entry_q <= s2_entry_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      hold_q     <= hold_d;
      rfd_en_q   <= rfd_en_d;
    end
  end

  // FIFO storage: written from S2 whenever a result leaves the pipeline.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; count_q gates its visibility, so stale contents are never observed.
    if (push) mem_q[wr_ptr_q] <= s2_entry_q;
  end

endmodule

// File: tb/tb_bounding_box_pipe.sv
// Self-checking bench for bounding_box_pipe with default parameters.
// Directed vectors come from a table with hand-computed boxes.
// Hand-written sequences cover backpressure/credit and reset mid-stream.
// Scissor vectors are compiled in with BOUNDING_BOX_SCISSOR_EN.
module tb_bounding_box_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        nd = 1'b0;
  logic        ds_rfd = 1'b0;
  logic        us_rfd, rdy, degen, cull;
  logic [15:0] v1x = '0, v1y = '0, v2x = '0, v2y = '0, v3x = '0, v3y = '0;
  logic [15:0] min_x, max_x, min_y, max_y;
`ifdef BOUNDING_BOX_SCISSOR_EN
  logic [15:0] sc_min_x = '0, sc_max_x = '0, sc_min_y = '0, sc_max_y = '0;
`endif

  int checks = 0;
  int failures = 0;

  localparam logic [15:0] SC_LO = 16'hFFFF;  // lowest key: -NaN with full mantissa
  localparam logic [15:0] SC_HI = 16'h7FFF;  // highest key: +NaN with full mantissa

  typedef struct {
    logic [15:0] v1x, v1y, v2x, v2y, v3x, v3y;
    logic [15:0] sminx, smaxx, sminy, smaxy;
    logic [15:0] eminx, emaxx, eminy, emaxy;
    logic        edegen, ecull;
  } vec_t;

  bounding_box_pipe dut (
    .clk     (clk),
    .rst     (rst),
    .nd      (nd),
    .us_rfd  (us_rfd),
    .v1_posX (v1x),
    .v1_posY (v1y),
    .v2_posX (v2x),
    .v2_posY (v2y),
    .v3_posX (v3x),
    .v3_posY (v3y),
    .ds_rfd  (ds_rfd),
    .rdy     (rdy),
    .fp_minX (min_x),
    .fp_maxX (max_x),
    .fp_minY (min_y),
    .fp_maxY (max_y),
    .degen   (degen),
    .cull    (cull)
`ifdef BOUNDING_BOX_SCISSOR_EN
    ,
    .sc_minX (sc_min_x),
    .sc_maxX (sc_max_x),
    .sc_minY (sc_min_y),
    .sc_maxY (sc_max_y)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_tri(input vec_t v);
    v1x = v.v1x; v1y = v.v1y; v2x = v.v2x; v2y = v.v2y; v3x = v.v3x; v3y = v.v3y;
`ifdef BOUNDING_BOX_SCISSOR_EN
    sc_min_x = v.sminx; sc_max_x = v.smaxx; sc_min_y = v.sminy; sc_max_y = v.smaxy;
`endif
  endtask

  function automatic vec_t mk(input logic [15:0] ax, ay, bx, by, cx, cy,
                              input logic [15:0] eminx, emaxx, eminy, emaxy,
                              input logic edegen);
    vec_t v;
    v.v1x = ax; v.v1y = ay; v.v2x = bx; v.v2y = by; v.v3x = cx; v.v3y = cy;
    v.sminx = SC_LO; v.smaxx = SC_HI; v.sminy = SC_LO; v.smaxy = SC_HI;
    v.eminx = eminx; v.emaxx = emaxx; v.eminy = eminy; v.emaxy = emaxy;
    v.edegen = edegen; v.ecull = 1'b0;
    return v;
  endfunction

  // Backpressure triangle i: minX = 0x2C00+i, maxX = 0x3A00.
  function automatic vec_t mk_bp(input int i);
    logic [15:0] x;
    x = 16'h2C00 + 16'(i);
    return mk(x, 16'h3400, 16'h3800, 16'h3C00, 16'h3A00, 16'h3900,
              x, 16'h3A00, 16'h3400, 16'h3C00, 1'b0);
  endfunction

  // One isolated triangle.
  // Sequence: accept, check latency, check the head, pop, check the held value.
  task automatic apply_vec(input vec_t v, input int idx);
    @(negedge clk);
    drive_tri(v);
    nd = 1'b1;
    ds_rfd = 1'b0;
    check($sformatf("v%0d us_rfd before accept", idx), us_rfd, 1);
    @(posedge clk); #1;
    nd = 1'b0;
    @(posedge clk); #1;
    check($sformatf("v%0d rdy at N+1", idx), rdy, 0);
    @(posedge clk); #1;
    check($sformatf("v%0d rdy at N+2", idx), rdy, 1);
    check($sformatf("v%0d minX", idx), min_x, v.eminx);
    check($sformatf("v%0d maxX", idx), max_x, v.emaxx);
    check($sformatf("v%0d minY", idx), min_y, v.eminy);
    check($sformatf("v%0d maxY", idx), max_y, v.emaxy);
    check($sformatf("v%0d degen", idx), degen, v.edegen);
    check($sformatf("v%0d cull", idx), cull, v.ecull);
    ds_rfd = 1'b1;
    @(posedge clk); #1;
    ds_rfd = 1'b0;
    check($sformatf("v%0d rdy after pop", idx), rdy, 0);
    check($sformatf("v%0d minX held", idx), min_x, v.eminx);
  endtask

  initial begin
    vec_t tbl[$];
    int   acc;
    int   pops;
    int   stale;
    logic r;
    logic rd;
    logic nd_now;
    logic [15:0] head;

    // Inputs: v1x v1y v2x v2y v3x v3y. Expected: minX maxX minY maxY degen.
    tbl.push_back(mk(16'h3400, 16'h3400, 16'h3800, 16'h3C00, 16'h3A00, 16'h3900,
                     16'h3400, 16'h3A00, 16'h3400, 16'h3C00, 1'b0));
    tbl.push_back(mk(16'hB400, 16'hB400, 16'h3800, 16'h3E00, 16'hBA00, 16'hBE80,
                     16'hBA00, 16'h3800, 16'hBE80, 16'h3E00, 1'b0));
    tbl.push_back(mk(16'hBE00, 16'hBE00, 16'h3D00, 16'h3D00, 16'h4000, 16'hC351,
                     16'hBE00, 16'h4000, 16'hC351, 16'h3D00, 1'b0));
    tbl.push_back(mk(16'h3C00, 16'h3400, 16'h3C00, 16'h3800, 16'h3C00, 16'h3A00,
                     16'h3C00, 16'h3C00, 16'h3400, 16'h3A00, 1'b1));
    tbl.push_back(mk(16'h8000, 16'h3400, 16'h0000, 16'h3800, 16'h0000, 16'h3A00,
                     16'h8000, 16'h0000, 16'h3400, 16'h3A00, 1'b0));
    tbl.push_back(mk(16'h3000, 16'h4400, 16'hC000, 16'h4400, 16'h3800, 16'h4400,
                     16'hC000, 16'h3800, 16'h4400, 16'h4400, 1'b1));
    // +Inf, +NaN and -Inf: -Inf is lowest; +NaN's key sorts above +Inf.
    tbl.push_back(mk(16'h7C00, 16'h0000, 16'h7E00, 16'h0000, 16'hFC00, 16'h0000,
                     16'hFC00, 16'h7E00, 16'h0000, 16'h0000, 1'b1));
`ifdef BOUNDING_BOX_SCISSOR_EN
    begin
      vec_t s;
      s = mk(16'hB800, 16'h3400, 16'h3800, 16'h3800, 16'h4000, 16'h3A00,
             16'h0000, 16'h3C00, 16'h3400, 16'h3A00, 1'b0);
      s.sminx = 16'h0000; s.smaxx = 16'h3C00; s.sminy = 16'h0000; s.smaxy = 16'h3C00;
      tbl.push_back(s);
      s = mk(16'h4400, 16'h3400, 16'h4800, 16'h3800, 16'h4600, 16'h3A00,
             16'h4400, 16'h3C00, 16'h3400, 16'h3A00, 1'b0);
      s.sminx = 16'h0000; s.smaxx = 16'h3C00; s.sminy = 16'h0000; s.smaxy = 16'h3C00;
      s.ecull = 1'b1;
      tbl.push_back(s);
    end
`endif

    // Reset state.
    #2 rst = 1'b0;
    #1;
    check("reset us_rfd", us_rfd, 0);
    check("reset rdy", rdy, 0);
    check("reset minX", min_x, 0);
    check("reset maxY", max_y, 0);
    check("reset degen", degen, 0);
    check("reset cull", cull, 0);
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("us_rfd after release", us_rfd, 1);

    // Directed table.
    for (int i = 0; i < tbl.size(); i++) apply_vec(tbl[i], i);

    // Backpressure: with ds_rfd low and nd held high, exactly DEPTH accepts occur.
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      drive_tri(mk_bp(acc));
      nd = 1'b1;
      ds_rfd = 1'b0;
      r = us_rfd;
      @(posedge clk);
      if (r) acc++;
    end
    #1;
    check("bp accept count", 32'(acc), 4);
    check("bp us_rfd when full", us_rfd, 0);
    check("bp rdy when full", rdy, 1);
    // First pop: us_rfd returns in the following cycle.
    @(negedge clk);
    drive_tri(mk_bp(acc));
    ds_rfd = 1'b1;
    check("bp pop0 minX", min_x, 16'h2C00);
    check("bp pop0 maxX", max_x, 16'h3A00);
    pops = 1;
    @(posedge clk); #1;
    check("bp us_rfd after pop", us_rfd, 1);
    // Refill while draining. Pops must follow accept order with no loss or duplication.
    for (int c = 0; c < 40 && pops < 8; c++) begin
      @(negedge clk);
      nd_now = (acc < 8);
      nd = nd_now;
      drive_tri(mk_bp(acc));
      ds_rfd = 1'b1;
      r = us_rfd;
      rd = rdy;
      head = min_x;
      @(posedge clk);
      if (r && nd_now) acc++;
      if (rd) begin
        check($sformatf("bp pop%0d order", pops), head, 16'h2C00 + 16'(pops));
        pops++;
      end
    end
    #1;
    nd = 1'b0;
    check("bp total accepts", 32'(acc), 8);
    check("bp total pops", 32'(pops), 8);
    check("bp drained rdy", rdy, 0);

    // Reset mid-stream: buffer 3 entries with 1 still in flight, then assert reset between edges.
    @(negedge clk);
    ds_rfd = 1'b0;
    acc = 0;
    for (int c = 0; c < 10 && acc < 4; c++) begin
      @(negedge clk);
      drive_tri(mk(16'h3C00, 16'h3000 + 16'(c), 16'h3C00, 16'h3800, 16'h3C00, 16'h3A00,
                   16'h3C00, 16'h3C00, 16'h3000, 16'h3A00, 1'b1));
      nd = 1'b1;
      r = us_rfd;
      @(posedge clk);
      if (r) acc++;
    end
    #1 nd = 1'b0;
    check("rst-mid accepts", 32'(acc), 4);
    @(posedge clk); #1;
    check("rst-mid rdy before", rdy, 1);
    check("rst-mid degen before", degen, 1);
    check("rst-mid minX before", min_x, 16'h3C00);
    #2 rst = 1'b0;
    #1;
    check("rst-mid rdy", rdy, 0);
    check("rst-mid minX", min_x, 0);
    check("rst-mid maxY", max_y, 0);
    check("rst-mid degen", degen, 0);
    check("rst-mid us_rfd", us_rfd, 0);
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("rst-mid us_rfd after release", us_rfd, 1);
    ds_rfd = 1'b1;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (rdy) stale++;
    end
    ds_rfd = 1'b0;
    check("rst-mid no stale entries", 32'(stale), 0);

    // Recovery: a normal triangle still goes through.
    apply_vec(tbl[0], 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
